// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op and state
// encodings, datapath widths and iteration count.
package muldiv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MULDIV_ITER = 32;
    localparam int unsigned CNT_W       = $clog2(MULDIV_ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b10
    } state_e;

    // Magnitude of a word; only negates when the op treats it as signed.
    function automatic logic [XLEN-1:0] abs_word(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? (XLEN'(0) - v) : v;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit (quotient MSB)
// into the partial remainder, subtract the divisor if it fits, and shift the
// resulting quotient bit into the LSB.
// Ports:
//   rem      in  32  partial remainder
//   quo      in  32  remaining dividend bits / quotient so far
//   divisor  in  32  divisor magnitude
//   rem_next out 32  next partial remainder
//   quo_next out 32  next quotient word
module div_restore_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted_c;
    logic [XLEN:0] diff_c;

    // rem < divisor on entry, so diff MSB is a clean borrow flag.
    assign shifted_c = {rem, quo[XLEN-1]};
    assign diff_c    = shifted_c - {1'b0, divisor};
    assign rem_next  = diff_c[XLEN] ? shifted_c[XLEN-1:0] : diff_c[XLEN-1:0];
    assign quo_next  = {quo[XLEN-2:0], ~diff_c[XLEN]};

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit. Iterative shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up in a final SIGN state. The
// signed result is staged and published to HI/LO together with a one-cycle
// Done pulse, so HI/LO only ever change when Done rises.
// Optional macro MULDIV_FAST_MULT_EN: MULT/MULTU use a single-cycle 64-bit
// multiplier and never leave IDLE.
// Ports:
//   clk        in   1  clock
//   CLR        in   1  synchronous active-high reset / pipeline flush
//   Start      in   1  begin an operation (sampled in IDLE only)
//   Op         in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A          in  32  multiplicand / dividend
//   B          in  32  multiplier / divisor
//   Busy       out  1  operation in flight (pipeline stall)
//   Done       out  1  one-cycle result-valid pulse
//   DivByZero  out  1  zero divisor, valid with Done
//   HI         out 32  high product word / remainder
//   LO         out 32  low product word / quotient
module ex_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        CLR,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Done,
    output logic        DivByZero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_e           state;
    op_e              op_q;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  opnd;       // multiplicand or divisor magnitude
    logic [XLEN-1:0]  a_raw;      // dividend as sampled, for the zero-divisor HI
    logic [XLEN-1:0]  acc_hi;     // product high / partial remainder
    logic [XLEN-1:0]  acc_lo;     // product low / quotient
    logic             neg_q;      // negate product or quotient
    logic             neg_r;      // negate remainder (dividend sign)
    logic [XLEN-1:0]  res_hi;
    logic [XLEN-1:0]  res_lo;
    logic             res_dbz;
    logic             res_pend;   // staged result publishes on the next edge

    logic             signed_op_c;
    logic [XLEN-1:0]  abs_a_c;
    logic [XLEN-1:0]  abs_b_c;
    logic [XLEN:0]    mul_sum_c;
    logic [XLEN-1:0]  div_rem_c;
    logic [XLEN-1:0]  div_quo_c;
    logic             fast_mul_c;
    logic [2*XLEN-1:0] fast_prod_c;

    assign signed_op_c = ~Op[0];
    assign abs_a_c     = abs_word(A, signed_op_c);
    assign abs_b_c     = abs_word(B, signed_op_c);

    // Shift-add: add multiplicand when the current multiplier bit is set.
    assign mul_sum_c = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};

    div_restore_step u_div_step (
        .rem      (acc_hi),
        .quo      (acc_lo),
        .divisor  (opnd),
        .rem_next (div_rem_c),
        .quo_next (div_quo_c)
    );

`ifdef MULDIV_FAST_MULT_EN
    assign fast_mul_c  = ~Op[1];
    assign fast_prod_c = signed_op_c
        ? (2*XLEN)'($signed({{XLEN{A[XLEN-1]}}, A}) * $signed({{XLEN{B[XLEN-1]}}, B}))
        : (2*XLEN)'({{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B});
`else
    assign fast_mul_c  = 1'b0;
    assign fast_prod_c = '0;
`endif

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (CLR) begin
            state     <= IDLE;
            op_q      <= OP_MULT;
            cnt       <= '0;
            opnd      <= '0;
            a_raw     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            res_hi    <= '0;
            res_lo    <= '0;
            res_dbz   <= 1'b0;
            res_pend  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            Done      <= res_pend;
            DivByZero <= res_pend & res_dbz;
            res_pend  <= 1'b0;
            if (res_pend) begin
                HI <= res_hi;
                LO <= res_lo;
            end

            case (state)
                IDLE: begin
                    if (Start) begin
                        op_q  <= op_e'(Op);
                        a_raw <= A;
                        neg_q <= signed_op_c & (A[XLEN-1] ^ B[XLEN-1]);
                        neg_r <= signed_op_c & A[XLEN-1];
                        if (fast_mul_c) begin
                            res_hi   <= fast_prod_c[2*XLEN-1:XLEN];
                            res_lo   <= fast_prod_c[XLEN-1:0];
                            res_dbz  <= 1'b0;
                            res_pend <= 1'b1;
                        end else begin
                            cnt    <= CNT_W'(MULDIV_ITER - 1);
                            acc_hi <= '0;
                            acc_lo <= Op[1] ? abs_a_c : abs_b_c;
                            opnd   <= Op[1] ? abs_b_c : abs_a_c;
                            state  <= CALC;
                            Busy   <= 1'b1;
                        end
                    end
                end

                CALC: begin
                    if (op_q[1]) begin
                        acc_hi <= div_rem_c;
                        acc_lo <= div_quo_c;
                    end else begin
                        acc_hi <= mul_sum_c[XLEN:1];
                        acc_lo <= {mul_sum_c[0], acc_lo[XLEN-1:1]};
                    end
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= SIGN;
                    end
                end

                SIGN: begin
                    res_dbz <= 1'b0;
                    case (op_q)
                        OP_MULT, OP_MULTU: begin
                            {res_hi, res_lo} <= neg_q ? ((2*XLEN)'(0) - {acc_hi, acc_lo})
                                                      : {acc_hi, acc_lo};
                        end
                        default: begin
                            if (opnd == '0) begin
                                res_hi  <= a_raw;
                                res_lo  <= '1;
                                res_dbz <= 1'b1;
                            end else begin
                                res_lo <= neg_q ? (XLEN'(0) - acc_lo) : acc_lo;
                                res_hi <= neg_r ? (XLEN'(0) - acc_hi) : acc_hi;
                            end
                        end
                    endcase
                    res_pend <= 1'b1;
                    state    <= IDLE;
                    Busy     <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: an arithmetic reference model tracks
// expected outputs per cycle; directed cases pin literal results, then random
// traffic with occasional flushes runs against the model.
module tb_ex_muldiv_unit;

    logic        clk;
    logic        CLR;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic        DivByZero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_checks = 0;
    int n_errors = 0;

    ex_muldiv_unit dut (
        .clk       (clk),
        .CLR       (CLR),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero),
        .HI        (HI),
        .LO        (LO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Arithmetic reference for one operation.
    function automatic void model_calc(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b, output logic [31:0] hi,
                                       output logic [31:0] lo, output logic dbz);
        longint      p;
        logic [63:0] u;
        int          sa;
        int          sb;
        sa  = $signed(a);
        sb  = $signed(b);
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin
                p = longint'(sa) * longint'(sb);
                {hi, lo} = p;
            end
            2'b01: begin
                u = {32'd0, a} * {32'd0, b};
                {hi, lo} = u;
            end
            2'b10: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = 32'd0;
                end else begin
                    lo = sa / sb;
                    hi = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    lo = 32'hFFFF_FFFF; hi = a; dbz = 1'b1;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Cycle-level expectation: outputs seen after each rising edge.
    int          cyc      = 0;
    int          busy_end = -1;
    int          pend_cyc = 0;
    bit          pend_v   = 0;
    logic [31:0] pend_hi, pend_lo;
    logic        pend_dbz;
    logic        exp_busy = 0, exp_done = 0, exp_dbz = 0;
    logic [31:0] exp_hi = 0, exp_lo = 0;
    bit          chk_en = 0;

    always @(posedge clk) begin
        cyc++;
        if (CLR) begin
            exp_busy = 0; exp_done = 0; exp_dbz = 0;
            exp_hi   = 0; exp_lo   = 0;
            pend_v   = 0; busy_end = -1;
            chk_en   = 1;
        end else begin
            exp_done = 0;
            exp_dbz  = 0;
            if (pend_v && cyc == pend_cyc) begin
                exp_hi   = pend_hi;
                exp_lo   = pend_lo;
                exp_done = 1;
                exp_dbz  = pend_dbz;
                pend_v   = 0;
            end
            if (Start && !exp_busy) begin
                model_calc(Op, A, B, pend_hi, pend_lo, pend_dbz);
                pend_v = 1;
`ifdef MULDIV_FAST_MULT_EN
                if (!Op[1]) begin
                    pend_cyc = cyc + 1;
                end else begin
                    pend_cyc = cyc + 34;
                    busy_end = cyc + 32;
                end
`else
                pend_cyc = cyc + 34;
                busy_end = cyc + 32;
`endif
            end
            exp_busy = (cyc <= busy_end);
        end
    end

    // Compare DUT against the model every cycle once reset has been seen.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(Busy), 32'(exp_busy));
            chk("done", 32'(Done), 32'(exp_done));
            chk("divbyzero", 32'(DivByZero), 32'(exp_dbz));
            chk("hi", HI, exp_hi);
            chk("lo", LO, exp_lo);
        end
    end

    task automatic wait_done(input string name, input logic [31:0] want_hi,
                             input logic [31:0] want_lo, input logic want_dbz);
        bit found;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (Done) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL %s_timeout: got no Done expected Done within 60 cycles", name);
        end else begin
            chk({name, "_hi"}, HI, want_hi);
            chk({name, "_lo"}, LO, want_lo);
            chk({name, "_dbz"}, 32'(DivByZero), 32'(want_dbz));
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] mh, ml;
        logic        md;

        CLR = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;

        // Pin the model against hand-computed results.
        model_calc(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mh, ml, md);
        chk("model_multu_hi", mh, 32'hFFFF_FFFE);
        chk("model_multu_lo", ml, 32'h0000_0001);
        model_calc(2'b00, 32'hFFFF_FFFD, 32'd5, mh, ml, md);
        chk("model_mult_lo", ml, 32'hFFFF_FFF1);
        model_calc(2'b10, 32'hFFFF_FFF9, 32'd2, mh, ml, md);
        chk("model_div_lo", ml, 32'hFFFF_FFFD);
        chk("model_div_hi", mh, 32'hFFFF_FFFF);
        model_calc(2'b11, 32'd9, 32'd4, mh, ml, md);
        chk("model_divu_lo", ml, 32'd2);

        repeat (3) @(negedge clk);
        CLR = 1'b0;
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 32'd0, 32'h8000_0000, 1'b0);

        issue(2'b11, 32'h64, 32'd0);
        wait_done("divu_zero", 32'h64, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("divu_zero_pulse", 32'(DivByZero), 32'd0);

        // Second Start while busy must be ignored.
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        Start = 1'b1; Op = 2'b10; A = 32'd1; B = 32'd0;
        @(negedge clk);
        Start = 1'b0;
        wait_done("repulse", 32'd2, 32'd14, 1'b0);

        // Flush mid-calculation.
        issue(2'b11, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        CLR = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
        chk("flush_busy", 32'(Busy), 32'd0);
        chk("flush_hi", HI, 32'd0);
        chk("flush_lo", LO, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_done_lo", LO, 32'd0);
        issue(2'b11, 32'd9, 32'd4);
        wait_done("divu_after_flush", 32'd1, 32'd2, 1'b0);

        // Random traffic with rare flushes.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            Start = ($urandom_range(3) == 0);
            Op    = 2'($urandom_range(3));
            A     = pick();
            B     = pick();
            CLR   = ($urandom_range(299) == 0);
        end
        @(negedge clk);
        Start = 1'b0; CLR = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
EX_MULDIV_UNIT -- requirements
Module: ex_muldiv_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port CLR  in  1  reset, synchronous, active-high; also used as pipeline flush.
REQ-003 SHALL have port Start  in  1  request to begin an operation; sampled only in IDLE.
REQ-004 SHALL have port Op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
REQ-005 SHALL have port A  in  32  operand rs (ID/EX RD1); multiplicand or dividend.
REQ-006 SHALL have port B  in  32  operand rt (ID/EX RD2); multiplier or divisor.
REQ-007 SHALL have port Busy  out  1  high while an operation is in flight; drives the pipeline stall.
REQ-008 SHALL have port Done  out  1  one-cycle pulse; HI/LO hold the new result in that cycle.
REQ-009 SHALL have port DivByZero  out  1  valid only while Done is high.
REQ-010 SHALL have port HI  out  32  high product word, or remainder.
REQ-011 SHALL have port LO  out  32  low product word, or quotient.

Function
REQ-012 SHALL implement states IDLE, CALC and SIGN.
REQ-013 SHALL, on an edge in IDLE with Start=1: latch Op, |A|, |B| and the operand signs (signed ops only); load the iteration counter with 31; go to CALC.
REQ-014 SHALL, in CALC, perform one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; go to SIGN after the counter-0 step (32 cycles total).
REQ-015 SHALL, in SIGN, negate the result as the signs require, write HI/LO, go to IDLE, and assert Done in the following cycle only.
REQ-016 SHALL, for the iterative path, raise Done during the cycle after the 34th edge following the edge that sampled Start.
REQ-017 SHALL hold Busy=1 in CALC and SIGN, and Busy=0 in IDLE (including the Done cycle).
REQ-018 SHALL ignore Start when Busy=1; Start during the Done cycle SHALL be accepted.
REQ-019 SHALL produce a 64-bit product {HI,LO}: two's complement for MULT, unsigned for MULTU.
REQ-020 SHALL truncate signed quotients toward zero; the remainder sign SHALL follow the dividend.
REQ-021 SHALL, for a zero divisor (DIV or DIVU), give LO=32'hFFFFFFFF, HI=A as sampled, and DivByZero=1 with Done.
REQ-022 SHALL, for DIV 32'h80000000 / 32'hFFFFFFFF, give LO=32'h80000000 and HI=0, with no flag.
REQ-023 SHALL hold HI/LO steady between Done pulses; no intermediate value shall be visible.

Reset
REQ-024 SHALL, on CLR=1 at any edge, set state=IDLE, HI=0, LO=0, Busy=0, Done=0 and DivByZero=0; CLR overrides Start.
REQ-025 SHALL, on CLR mid-operation, discard the operation with no Done pulse; Busy SHALL be 0 in the next cycle.

Configuration
REQ-026 SHALL support macro MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle 64-bit multiply; Done is high in the cycle after the edge that sampled Start; the module stays in IDLE; Busy stays 0.
- Undefined: multiply uses the 34-edge iterative path. Division is always iterative.

Structure
REQ-027 SHALL take from shared package muldiv_pkg: the Op encodings, the state encoding, and constant MULDIV_ITER=32.
REQ-028 SHALL put one restoring divide iteration in combinational sub-module div_restore_step (in: partial remainder, quotient, divisor; out: next remainder, next quotient).

Verification
REQ-029 SHALL cover: MULTU A=FFFFFFFF B=FFFFFFFF -> HI=FFFFFFFE, LO=00000001; Done at edge 34 (edge 1 with macro).
REQ-030 SHALL cover: MULT A=FFFFFFFD(-3) B=5 -> HI=FFFFFFFF, LO=FFFFFFF1.
REQ-031 SHALL cover: DIV A=FFFFFFF9(-7) B=2 -> LO=FFFFFFFD, HI=FFFFFFFF; then DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
REQ-032 SHALL cover: DIVU A=64 B=0 -> LO=FFFFFFFF, HI=00000064, DivByZero=1 for one cycle.
REQ-033 SHALL cover: Start re-pulsed while Busy -> ignored; the original result is unchanged at edge 34.
REQ-034 SHALL cover: CLR at cycle 10 of CALC -> Busy=0 next cycle, no Done, HI=LO=0; a following DIVU 9/4 -> LO=2, HI=1.
